// File: rtl/hbm_bench_scheduler_if.sv
// Engine-side bus of the HBM benchmark scheduler: launch pulses and parameters
// out to the engines, completion pulses and latency samples back.
interface hbm_bench_scheduler_if #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned PARAMS_BITS = 256,
  parameter int unsigned LAT_W       = 16
);
  logic [NUM_ENGINES-1:0]       eng_start;
  logic [PARAMS_BITS-1:0]       eng_params;
  logic [NUM_ENGINES-1:0]       eng_end;
  logic [NUM_ENGINES-1:0]       eng_lat_valid;
  logic [NUM_ENGINES*LAT_W-1:0] eng_lat;

  modport master (
    output eng_start,
    output eng_params,
    input  eng_end,
    input  eng_lat_valid,
    input  eng_lat
  );

  modport slave (
    input  eng_start,
    input  eng_params,
    output eng_end,
    output eng_lat_valid,
    output eng_lat
  );
endinterface

// File: rtl/hbm_bench_scheduler.sv
// HBM benchmark scheduler: latches a run descriptor, launches the enabled engines in parallel
// or one at a time, collects end_of_exec pulses and latency samples, and reports done/timeout.
module hbm_bench_scheduler #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned PARAMS_BITS = 256,
  parameter int unsigned LAT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode_seq,
  input  logic [NUM_ENGINES-1:0] engine_mask,
  input  logic [PARAMS_BITS-1:0] params_in,
  input  logic [31:0]            timeout_cycles,
  hbm_bench_scheduler_if.master  eng,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [63:0]            total_cycles,
  output logic [63:0]            lat_sum,
  output logic [31:0]            lat_cnt,
  output logic [LAT_W-1:0]       lat_min,
  output logic [LAT_W-1:0]       lat_max,
  output logic [31:0]            lat_drop
);

  localparam int unsigned IdxW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StNext, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   mode_seq_q, mode_seq_d;
  logic [NUM_ENGINES-1:0] act_mask_q, act_mask_d;
  logic [PARAMS_BITS-1:0] params_q, params_d;
  logic [31:0]            timeout_q, timeout_d;
  logic [IdxW-1:0]        cur_q, cur_d;
  logic [NUM_ENGINES-1:0] done_bits_q, done_bits_d;
  logic [31:0]            wait_cnt_q, wait_cnt_d;
  logic [63:0]            total_q, total_d;
  logic [63:0]            lat_sum_q, lat_sum_d;
  logic [31:0]            lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]       lat_min_q, lat_min_d;
  logic [LAT_W-1:0]       lat_max_q, lat_max_d;
  logic [31:0]            lat_drop_q, lat_drop_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   done_q, done_d;

  logic [IdxW-1:0]        first_idx;
  logic [IdxW-1:0]        next_idx;
  logic                   next_found;
  logic [NUM_ENGINES-1:0] lat_vec;
  logic [LAT_W-1:0]       sample;
  logic [31:0]            vld_cnt;
  logic                   par_done;
  logic                   seq_done;
  logic                   to_hit;

  // Index helpers: lowest requested engine, next active engine above cur, and the latency sample.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    sample     = '0;
    vld_cnt    = '0;
    lat_vec    = eng.eng_lat_valid & act_mask_q;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (engine_mask[i]) first_idx = IdxW'(i);
      if (act_mask_q[i] && (i > int'(cur_q))) begin
        next_idx   = IdxW'(i);
        next_found = 1'b1;
      end
      if (lat_vec[i]) sample = eng.eng_lat[i*LAT_W +: LAT_W];
    end
    for (int i = 0; i < NUM_ENGINES; i++) begin
      vld_cnt = vld_cnt + 32'(lat_vec[i]);
    end
  end

  assign par_done = ((done_bits_q | eng.eng_end) & act_mask_q) == act_mask_q;
  assign seq_done = eng.eng_end[cur_q];
  assign to_hit   = (timeout_q != 32'd0) && (wait_cnt_q == timeout_q - 32'd1);

  // Next-state logic for the run FSM and all run statistics.
  always_comb begin
    state_d       = state_q;
    mode_seq_d    = mode_seq_q;
    act_mask_d    = act_mask_q;
    params_d      = params_q;
    timeout_d     = timeout_q;
    cur_d         = cur_q;
    done_bits_d   = done_bits_q;
    wait_cnt_d    = wait_cnt_q;
    total_d       = total_q;
    lat_sum_d     = lat_sum_q;
    lat_cnt_d     = lat_cnt_q;
    lat_min_d     = lat_min_q;
    lat_max_d     = lat_max_q;
    lat_drop_d    = lat_drop_q;
    timeout_err_d = timeout_err_q;
    done_d        = (state_q == StDone);
    eng.eng_start = '0;

    if (state_q inside {StLaunch, StWait, StNext}) total_d = total_q + 64'd1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_seq_d    = mode_seq;
          act_mask_d    = engine_mask;
          params_d      = params_in;
          timeout_d     = timeout_cycles;
          cur_d         = first_idx;
          done_bits_d   = '0;
          total_d       = '0;
          lat_sum_d     = '0;
          lat_cnt_d     = '0;
          lat_min_d     = '1;
          lat_max_d     = '0;
          lat_drop_d    = '0;
          timeout_err_d = 1'b0;
          state_d       = (engine_mask == '0) ? StDone : StLaunch;
        end
      end
      StLaunch: begin
        eng.eng_start = mode_seq_q ? (NUM_ENGINES'(1) << cur_q) : act_mask_q;
        wait_cnt_d    = '0;
        state_d       = StWait;
      end
      StWait: begin
        done_bits_d = done_bits_q | (eng.eng_end & act_mask_q);
        wait_cnt_d  = wait_cnt_q + 32'd1;
        if (vld_cnt != 32'd0) begin
          lat_sum_d  = lat_sum_q + 64'(sample);
          lat_cnt_d  = lat_cnt_q + 32'd1;
          lat_drop_d = lat_drop_q + (vld_cnt - 32'd1);
          if (sample < lat_min_q) lat_min_d = sample;
          if (sample > lat_max_q) lat_max_d = sample;
        end
        // Completion takes priority over a timeout landing in the same cycle.
        if (mode_seq_q ? seq_done : par_done) begin
          state_d = mode_seq_q ? StNext : StDone;
        end else if (to_hit) begin
          timeout_err_d = 1'b1;
          state_d       = StDone;
        end
      end
      StNext: begin
        cur_d   = next_found ? next_idx : cur_q;
        state_d = next_found ? StLaunch : StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and statistics registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      mode_seq_q    <= 1'b0;
      act_mask_q    <= '0;
      params_q      <= '0;
      timeout_q     <= '0;
      cur_q         <= '0;
      done_bits_q   <= '0;
      wait_cnt_q    <= '0;
      total_q       <= '0;
      lat_sum_q     <= '0;
      lat_cnt_q     <= '0;
      lat_min_q     <= '1;
      lat_max_q     <= '0;
      lat_drop_q    <= '0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_seq_q    <= mode_seq_d;
      act_mask_q    <= act_mask_d;
      params_q      <= params_d;
      timeout_q     <= timeout_d;
      cur_q         <= cur_d;
      done_bits_q   <= done_bits_d;
      wait_cnt_q    <= wait_cnt_d;
      total_q       <= total_d;
      lat_sum_q     <= lat_sum_d;
      lat_cnt_q     <= lat_cnt_d;
      lat_min_q     <= lat_min_d;
      lat_max_q     <= lat_max_d;
      lat_drop_q    <= lat_drop_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= done_d;
    end
  end

  assign eng.eng_params = params_q;
  assign busy           = (state_q != StIdle) && (state_q != StDone);
  assign done           = done_q;
  assign timeout_err    = timeout_err_q;
  assign total_cycles   = total_q;
  assign lat_sum        = lat_sum_q;
  assign lat_cnt        = lat_cnt_q;
  assign lat_min        = lat_min_q;
  assign lat_max        = lat_max_q;
  assign lat_drop       = lat_drop_q;

endmodule
